// File: rtl/gpio_bus_arbiter_if.sv
// Signal bundle for gpio_bus_arbiter: two requester ports, the downstream
// GPIO-wrapper port and status flags. The arbiter uses 'slave', its environment 'master'.
interface gpio_bus_arbiter_if;
    logic        m0_stb_i;
    logic [6:0]  m0_adr_i;
    logic [3:0]  m0_byte_sel_i;
    logic        m0_we_i;
    logic [31:0] m0_dat_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o;
    logic        m1_stb_i;
    logic [6:0]  m1_adr_i;
    logic [3:0]  m1_byte_sel_i;
    logic        m1_we_i;
    logic [31:0] m1_dat_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o;
    logic        stb_o;
    logic [6:0]  adr_o;
    logic [3:0]  byte_sel_o;
    logic        we_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        init_done_o;
    logic        timeout_o;
    logic        busy_o;

    modport slave (
        input  m0_stb_i, m0_adr_i, m0_byte_sel_i, m0_we_i, m0_dat_i,
        output m0_dat_o, m0_ack_o,
        input  m1_stb_i, m1_adr_i, m1_byte_sel_i, m1_we_i, m1_dat_i,
        output m1_dat_o, m1_ack_o,
        output stb_o, adr_o, byte_sel_o, we_o, dat_o,
        input  dat_i, ack_i,
        output init_done_o, timeout_o, busy_o
    );

    modport master (
        output m0_stb_i, m0_adr_i, m0_byte_sel_i, m0_we_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o,
        output m1_stb_i, m1_adr_i, m1_byte_sel_i, m1_we_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o,
        input  stb_o, adr_o, byte_sel_o, we_o, dat_o,
        output dat_i, ack_i,
        input  init_done_o, timeout_o, busy_o
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin front end for xilinx_gpio_wrapper: replays a fixed register init
// sequence after reset, then shares the slave port between two requesters.
module gpio_bus_arbiter #(
    parameter logic        DUAL_CHANNEL   = 1'b0,
    parameter logic        INTERRUPT_EN   = 1'b1,
    parameter logic [31:0] DOUT_DEFAULT   = 32'h0000_0000,
    parameter logic [31:0] TRI_DEFAULT    = 32'hFFFF_FFFF,
    parameter logic [31:0] DOUT2_DEFAULT  = 32'h0000_0000,
    parameter logic [31:0] TRI2_DEFAULT   = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input logic               clk_i,
    input logic               rst_i,
    gpio_bus_arbiter_if.slave bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        I_DATA, I_TRI, I_DATA2, I_TRI2, I_IER, I_GIER, IDLE, BUS, RESP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last_grant, last_grant_n;
    logic             stb, stb_n, we, we_n;
    logic [6:0]       adr, adr_n;
    logic [3:0]       bsel, bsel_n;
    logic [31:0]      wdat, wdat_n, m0_rdat, m0_rdat_n, m1_rdat, m1_rdat_n;
    logic             m0_ack, m0_ack_n, m1_ack, m1_ack_n;
    logic             init_done, init_done_n, timeout, timeout_n, busy, busy_n;
    logic             xfer_done, pick1, wd_fire;
    logic [31:0]      xfer_rdat;

    function automatic state_t init_next(input state_t s);
        case (s)
            I_DATA:  return I_TRI;
            I_TRI:   return DUAL_CHANNEL ? I_DATA2 : (INTERRUPT_EN ? I_IER : IDLE);
            I_DATA2: return I_TRI2;
            I_TRI2:  return INTERRUPT_EN ? I_IER : IDLE;
            I_IER:   return I_GIER;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic [6:0] init_adr(input state_t s);
        case (s)
            I_DATA:  return 7'h00;
            I_TRI:   return 7'h01;
            I_DATA2: return 7'h02;
            I_TRI2:  return 7'h03;
            I_IER:   return 7'h4A;
            default: return 7'h47;
        endcase
    endfunction

    function automatic logic [31:0] init_dat(input state_t s);
        case (s)
            I_DATA:  return DOUT_DEFAULT;
            I_TRI:   return TRI_DEFAULT;
            I_DATA2: return DOUT2_DEFAULT;
            I_TRI2:  return TRI2_DEFAULT;
            I_IER:   return {30'b0, DUAL_CHANNEL, 1'b1};
            default: return 32'h8000_0000;
        endcase
    endfunction

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        last_grant_n = last_grant;
        stb_n        = stb;
        adr_n        = adr;
        bsel_n       = bsel;
        we_n         = we;
        wdat_n       = wdat;
        m0_rdat_n    = m0_rdat;
        m1_rdat_n    = m1_rdat;
        m0_ack_n     = 1'b0;
        m1_ack_n     = 1'b0;
        init_done_n  = init_done;
        timeout_n    = timeout;
        xfer_done    = 1'b0;
        xfer_rdat    = '0;
        pick1        = 1'b0;
        wd_fire      = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST);

        case (state)
            I_DATA, I_TRI, I_DATA2, I_TRI2, I_IER, I_GIER, BUS: begin
                // stb is raised one cycle into the state; ack_i before that is ignored
                if (!stb) begin
                    stb_n = 1'b1;
                    cnt_n = '0;
                    if (state != BUS) begin
                        adr_n  = init_adr(state);
                        wdat_n = init_dat(state);
                        we_n   = 1'b1;
                        bsel_n = 4'hF;
                    end
                end else if (bus.ack_i) begin
                    stb_n     = 1'b0;
                    xfer_done = 1'b1;
                    xfer_rdat = bus.dat_i;
                end else if (wd_fire) begin
                    stb_n     = 1'b0;
                    xfer_done = 1'b1;
                    xfer_rdat = ERR_DATA;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end

                if (xfer_done) begin
                    if (state == BUS) begin
                        state_n = RESP;
                        if (last_grant) begin
                            m1_rdat_n = xfer_rdat;
                            m1_ack_n  = 1'b1;
                        end else begin
                            m0_rdat_n = xfer_rdat;
                            m0_ack_n  = 1'b1;
                        end
                    end else begin
                        state_n = init_next(state);
                        if (state_n == IDLE) init_done_n = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (bus.m0_stb_i || bus.m1_stb_i) begin
                    pick1        = bus.m1_stb_i && (!bus.m0_stb_i || !last_grant);
                    last_grant_n = pick1;
                    state_n      = BUS;
                    cnt_n        = '0;
                    adr_n        = pick1 ? bus.m1_adr_i      : bus.m0_adr_i;
                    bsel_n       = pick1 ? bus.m1_byte_sel_i : bus.m0_byte_sel_i;
                    we_n         = pick1 ? bus.m1_we_i       : bus.m0_we_i;
                    wdat_n       = pick1 ? bus.m1_dat_i      : bus.m0_dat_i;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = I_DATA;
        endcase

        busy_n = stb_n || (state_n == BUS);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= I_DATA;
            cnt        <= '0;
            last_grant <= 1'b1;
            stb        <= 1'b0;
            adr        <= '0;
            bsel       <= '0;
            we         <= 1'b0;
            wdat       <= '0;
            m0_rdat    <= '0;
            m1_rdat    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            init_done  <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_grant <= last_grant_n;
            stb        <= stb_n;
            adr        <= adr_n;
            bsel       <= bsel_n;
            we         <= we_n;
            wdat       <= wdat_n;
            m0_rdat    <= m0_rdat_n;
            m1_rdat    <= m1_rdat_n;
            m0_ack     <= m0_ack_n;
            m1_ack     <= m1_ack_n;
            init_done  <= init_done_n;
            timeout    <= timeout_n;
            busy       <= busy_n;
        end
    end

    assign bus.stb_o       = stb;
    assign bus.adr_o       = adr;
    assign bus.byte_sel_o  = bsel;
    assign bus.we_o        = we;
    assign bus.dat_o       = wdat;
    assign bus.m0_dat_o    = m0_rdat;
    assign bus.m1_dat_o    = m1_rdat;
    assign bus.m0_ack_o    = m0_ack;
    assign bus.m1_ack_o    = m1_ack;
    assign bus.init_done_o = init_done;
    assign bus.timeout_o   = timeout;
    assign bus.busy_o      = busy;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench for gpio_bus_arbiter: dut_a (single channel, short watchdog)
// carries the traffic tests, dut_b (dual channel) checks the longer init sequence.
module tb_gpio_bus_arbiter;

    typedef struct {
        logic [6:0]  adr;
        logic        we;
        logic [3:0]  bsel;
        logic [31:0] dat;
        int          len;
    } ds_t;

    typedef struct {
        int          who;
        logic [31:0] dat;
        bit          to;
    } ack_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_bus_arbiter_if a ();
    gpio_bus_arbiter_if b ();

    gpio_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a));
    gpio_bus_arbiter #(.DUAL_CHANNEL(1'b1)) dut_b (.clk_i(clk), .rst_i(rst), .bus(b));

    ds_t  exp_ds[$];
    ds_t  exp_b[$];
    ack_t exp_ack[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int          resp_delay = 2;
    logic [31:0] resp_base  = 32'h0000_00A5;
    bit          resp_hang  = 1'b0;
    bit          stale_req  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_ds(input logic [6:0] adr, input logic we, input logic [3:0] bsel,
                           input logic [31:0] dat, input int len);
        ds_t e;
        e.adr = adr; e.we = we; e.bsel = bsel; e.dat = dat; e.len = len;
        exp_ds.push_back(e);
    endtask

    task automatic push_b(input logic [6:0] adr, input logic [31:0] dat);
        ds_t e;
        e.adr = adr; e.we = 1'b1; e.bsel = 4'hF; e.dat = dat; e.len = 1;
        exp_b.push_back(e);
    endtask

    task automatic push_ack(input int who, input logic [31:0] dat, input bit to);
        ack_t e;
        e.who = who; e.dat = dat; e.to = to;
        exp_ack.push_back(e);
    endtask

    task automatic push_init();
        push_ds(7'h00, 1'b1, 4'hF, 32'h0000_0000, 2);
        push_ds(7'h01, 1'b1, 4'hF, 32'hFFFF_FFFF, 2);
        push_ds(7'h4A, 1'b1, 4'hF, 32'h0000_0001, 2);
        push_ds(7'h47, 1'b1, 4'hF, 32'h8000_0000, 2);
        push_b(7'h00, 32'h0000_0000);
        push_b(7'h01, 32'hFFFF_FFFF);
        push_b(7'h02, 32'h0000_0000);
        push_b(7'h03, 32'hFFFF_FFFF);
        push_b(7'h4A, 32'h0000_0003);
        push_b(7'h47, 32'h8000_0000);
    endtask

    task automatic set_m0(input logic [6:0] adr, input logic we, input logic [3:0] bsel, input logic [31:0] dat);
        a.m0_adr_i = adr; a.m0_we_i = we; a.m0_byte_sel_i = bsel; a.m0_dat_i = dat; a.m0_stb_i = 1'b1;
    endtask

    task automatic set_m1(input logic [6:0] adr, input logic we, input logic [3:0] bsel, input logic [31:0] dat);
        a.m1_adr_i = adr; a.m1_we_i = we; a.m1_byte_sel_i = bsel; a.m1_dat_i = dat; a.m1_stb_i = 1'b1;
    endtask

    task automatic wait_ack(input string name, output int who);
        who = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (a.m0_ack_o) begin who = 0; return; end
            if (a.m1_ack_o) begin who = 1; return; end
        end
        n_chk++; n_fail++;
        $display("FAIL %s: no requester ack within 64 cycles, required one", name);
    endtask

    task automatic wait_init(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a.init_done_o) return;
        end
        n_chk++; n_fail++;
        $display("FAIL %s: init_done_o still 0 after 200 cycles, required 1", name);
    endtask

    // Downstream responder for dut_a
    initial begin
        int cnt;
        cnt = 0;
        a.ack_i = 1'b0;
        a.dat_i = '0;
        forever begin
            @(negedge clk);
            #1;
            if (a.stb_o && !resp_hang) cnt++;
            else cnt = 0;
            a.ack_i = stale_req || (a.stb_o && !resp_hang && cnt == resp_delay);
            a.dat_i = resp_base ^ {25'b0, a.adr_o};
        end
    end

    // Downstream transaction monitor for dut_a
    initial begin
        int  len;
        bit  prev, have;
        ds_t e;
        len = 0; prev = 1'b0; have = 1'b0;
        forever begin
            @(negedge clk);
            if (a.stb_o && !prev) begin
                len = 0;
                if (exp_ds.size() == 0) begin
                    have = 1'b0;
                    n_chk++; n_fail++;
                    $display("FAIL ds_unexpected: got strobe to adr %h, required none", a.adr_o);
                end else begin
                    e = exp_ds.pop_front();
                    have = 1'b1;
                    chk("ds_adr", a.adr_o, e.adr);
                    chk("ds_we", a.we_o, e.we);
                    chk("ds_bsel", a.byte_sel_o, e.bsel);
                    chk("ds_dat", a.dat_o, e.dat);
                    chk("ds_busy", a.busy_o, 1);
                end
            end else if (a.stb_o && have) begin
                chk("ds_hold_adr", a.adr_o, e.adr);
                chk("ds_hold_dat", a.dat_o, e.dat);
            end
            if (a.stb_o) len++;
            if (!a.stb_o && prev && have && e.len != 0) chk("ds_stb_len", len, e.len);
            prev = a.stb_o;
        end
    end

    // Requester ack monitor for dut_a
    initial begin
        bit   prev_ack;
        ack_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (a.m0_ack_o || a.m1_ack_o) begin
                if (prev_ack) chk("ack_pulse_width", 2, 1);
                if (a.m0_ack_o && a.m1_ack_o) chk("ack_both", 1, 0);
                if (exp_ack.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL ack_unexpected: got m0_ack=%0b m1_ack=%0b, required none",
                             a.m0_ack_o, a.m1_ack_o);
                end else begin
                    e = exp_ack.pop_front();
                    chk("ack_who", a.m1_ack_o ? 1 : 0, e.who);
                    chk("ack_dat", (e.who == 1) ? a.m1_dat_o : a.m0_dat_o, e.dat);
                    chk("ack_vs_ack_i", a.ack_i, e.to ? 0 : 1);
                    chk("ack_init_done", a.init_done_o, 1);
                end
            end
            prev_ack = a.m0_ack_o || a.m1_ack_o;
        end
    end

    // Responder and init-sequence monitor for dut_b
    initial begin
        bit  prev;
        ds_t e;
        prev = 1'b0;
        b.ack_i = 1'b0;
        b.dat_i = '0;
        forever begin
            @(negedge clk);
            if (b.stb_o && !prev) begin
                if (exp_b.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL b_unexpected: got strobe to adr %h, required none", b.adr_o);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_adr", b.adr_o, e.adr);
                    chk("b_dat", b.dat_o, e.dat);
                    chk("b_we", b.we_o, e.we);
                end
            end
            prev = b.stb_o;
            #1;
            b.ack_i = b.stb_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "bench hung");
    end

    initial begin
        int who;
        a.m0_stb_i = 0; a.m0_adr_i = '0; a.m0_byte_sel_i = '0; a.m0_we_i = 0; a.m0_dat_i = '0;
        a.m1_stb_i = 0; a.m1_adr_i = '0; a.m1_byte_sel_i = '0; a.m1_we_i = 0; a.m1_dat_i = '0;
        b.m0_stb_i = 0; b.m0_adr_i = '0; b.m0_byte_sel_i = '0; b.m0_we_i = 0; b.m0_dat_i = '0;
        b.m1_stb_i = 0; b.m1_adr_i = '0; b.m1_byte_sel_i = '0; b.m1_we_i = 0; b.m1_dat_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_stb", a.stb_o, 0);
        chk("rst_adr", a.adr_o, 0);
        chk("rst_bsel", a.byte_sel_o, 0);
        chk("rst_we", a.we_o, 0);
        chk("rst_dat", a.dat_o, 0);
        chk("rst_acks", {a.m0_ack_o, a.m1_ack_o}, 0);
        chk("rst_m0_dat", a.m0_dat_o, 0);
        chk("rst_m1_dat", a.m1_dat_o, 0);
        chk("rst_flags", {a.init_done_o, a.timeout_o, a.busy_o}, 0);

        // Init sequence with m0 already requesting a read of GPIO_DATA
        push_init();
        set_m0(7'h00, 1'b0, 4'hF, 32'h1234_5678);
        push_ds(7'h00, 1'b0, 4'hF, 32'h1234_5678, 3);
        push_ack(0, 32'h0000_00A5, 1'b0);
        rst = 1'b0;
        wait_init("init_done");
        resp_delay = 3;
        wait_ack("m0_read", who);
        a.m0_stb_i = 1'b0;
        chk("m0_read_who", who, 0);

        // m1 write whose ack lands on the same cycle the watchdog would fire
        resp_delay = 8;
        set_m1(7'h05, 1'b1, 4'hF, 32'hCAFE_0001);
        push_ds(7'h05, 1'b1, 4'hF, 32'hCAFE_0001, 8);
        push_ack(1, 32'h0000_00A0, 1'b0);
        wait_ack("ack_vs_timeout", who);
        a.m1_stb_i = 1'b0;
        chk("ack_beats_timeout", a.timeout_o, 0);

        // Both requesters contend continuously: grants must alternate
        resp_delay = 3;
        set_m0(7'h10, 1'b1, 4'h3, 32'h1111_0000);
        set_m1(7'h11, 1'b0, 4'hF, 32'h0000_0000);
        push_ds(7'h10, 1'b1, 4'h3, 32'h1111_0000, 3);
        push_ds(7'h11, 1'b0, 4'hF, 32'h0000_0000, 3);
        push_ack(0, 32'h0000_00B5, 1'b0);
        push_ack(1, 32'h0000_00B4, 1'b0);
        wait_ack("alt1", who);
        chk("alt1_who", who, 0);
        set_m0(7'h12, 1'b1, 4'hC, 32'h2222_0000);
        push_ds(7'h12, 1'b1, 4'hC, 32'h2222_0000, 3);
        push_ack(0, 32'h0000_00B7, 1'b0);
        wait_ack("alt2", who);
        chk("alt2_who", who, 1);
        set_m1(7'h13, 1'b0, 4'hF, 32'h0000_0000);
        push_ds(7'h13, 1'b0, 4'hF, 32'h0000_0000, 3);
        push_ack(1, 32'h0000_00B6, 1'b0);
        wait_ack("alt3", who);
        chk("alt3_who", who, 0);
        a.m0_stb_i = 1'b0;
        wait_ack("alt4", who);
        chk("alt4_who", who, 1);
        a.m1_stb_i = 1'b0;

        // Hung downstream on an m1 read: watchdog fires after 8 strobe cycles
        resp_hang = 1'b1;
        set_m1(7'h06, 1'b0, 4'hF, 32'h0000_0000);
        push_ds(7'h06, 1'b0, 4'hF, 32'h0000_0000, 8);
        push_ack(1, 32'hDEAD_BEEF, 1'b1);
        wait_ack("timeout_ack", who);
        a.m1_stb_i = 1'b0;
        chk("timeout_who", who, 1);
        chk("timeout_flag", a.timeout_o, 1);
        repeat (4) @(negedge clk);
        stale_req = 1'b1;
        @(negedge clk);
        stale_req = 1'b0;
        resp_hang = 1'b0;
        repeat (6) @(negedge clk);
        chk("stale_m1_dat", a.m1_dat_o, 32'hDEAD_BEEF);
        chk("stale_stb", a.stb_o, 0);
        chk("stale_busy", a.busy_o, 0);
        chk("timeout_sticky", a.timeout_o, 1);

        // Recovery after the timeout
        resp_delay = 2;
        set_m1(7'h07, 1'b1, 4'hF, 32'h0BAD_F00D);
        push_ds(7'h07, 1'b1, 4'hF, 32'h0BAD_F00D, 2);
        push_ack(1, 32'h0000_00A2, 1'b0);
        wait_ack("recover", who);
        a.m1_stb_i = 1'b0;
        chk("recover_who", who, 1);

        // Reset while a downstream strobe is outstanding
        resp_hang = 1'b1;
        set_m0(7'h08, 1'b0, 4'hF, 32'h0000_0000);
        push_ds(7'h08, 1'b0, 4'hF, 32'h0000_0000, 0);
        for (int i = 0; i < 16 && !a.stb_o; i++) @(negedge clk);
        chk("pre_reset_stb", a.stb_o, 1);
        rst = 1'b1;
        a.m0_stb_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_stb", a.stb_o, 0);
        chk("mid_rst_acks", {a.m0_ack_o, a.m1_ack_o}, 0);
        chk("mid_rst_init_done", a.init_done_o, 0);
        chk("mid_rst_timeout", a.timeout_o, 0);
        chk("mid_rst_busy", a.busy_o, 0);
        chk("mid_rst_m1_dat", a.m1_dat_o, 0);
        resp_hang = 1'b0;
        push_init();
        rst = 1'b0;
        wait_init("reinit_done");
        repeat (20) @(negedge clk);

        chk("b_init_done", b.init_done_o, 1);
        chk("b_timeout", b.timeout_o, 0);
        chk("ds_queue_empty", exp_ds.size(), 0);
        chk("ack_queue_empty", exp_ack.size(), 0);
        chk("b_queue_empty", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
